// File: rtl/jk_exciter.sv
// jk_exciter: drives J/K excitation for an external JK bank toward a target word, with feedback check and retry
module jk_exciter #(
    parameter int WIDTH     = 4,
    parameter bit DC_POLICY = 1'b0,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [WIDTH-1:0] DCV = {WIDTH{DC_POLICY}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_q, cur_q, tgt_nxt, cur_nxt, j_nxt, k_nxt;
    logic [2:0]       retry;
    logic             live, take, hit, again, give_up;

    assign tgt_ready = live && state == IDLE;
    assign busy      = state != IDLE;
    assign take      = tgt_valid && tgt_ready;
    assign hit       = state == CHECK && q_fb == tgt_q;
    assign again     = state == CHECK && !hit && retry < 3'(MAX_RETRY);
    assign give_up   = state == CHECK && !hit && !(retry < 3'(MAX_RETRY));

    // state register; reset parks the FSM in IDLE immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: DRIVE always lasts one cycle, CHECK either retries or finishes
    always_comb begin
        state_nxt = take ? DRIVE : state == DRIVE ? CHECK : again ? DRIVE : IDLE;
    end

    // excitation for the upcoming DRIVE cycle, computed from the values being latched so j/k can be registered
    always_comb begin
        tgt_nxt = take ? tgt_data : tgt_q;
        cur_nxt = (take || again) ? q_fb : cur_q;
        j_nxt   = state_nxt == DRIVE ? ((~cur_nxt & tgt_nxt) | (cur_nxt & DCV)) : '0;
        k_nxt   = state_nxt == DRIVE ? ((cur_nxt & ~tgt_nxt) | (~cur_nxt & DCV)) : '0;
    end

    // datapath and status registers; err set takes priority over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q <= '0;
            cur_q <= '0;
            retry <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            live  <= 1'b0;
        end else begin
            tgt_q <= tgt_nxt;
            cur_q <= cur_nxt;
            retry <= take ? 3'd0 : again ? 3'(retry + 3'd1) : retry;
            j     <= j_nxt;
            k     <= k_nxt;
            done  <= hit;
            err   <= give_up || (err && !err_clr);
            live  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jk_exciter.sv
// tb_jk_exciter: randomized self-checking bench for jk_exciter with JK bank models and a transaction-level reference
module tb_jk_exciter;
    localparam int MAXR = 2;

    logic       clk = 1'b0, rst_n = 1'b0, tgt_valid = 1'b0, err_clr = 1'b0;
    logic [3:0] tgt_data = 4'h0, stuck = 4'h0;
    logic [3:0] b0 = 4'h0, b1 = 4'h0, j0, k0, j1, k1;
    logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
    logic [3:0] mq = 4'h0;
    logic       exp_err = 1'b0;
    int         checks = 0, fails = 0;

    jk_exciter #(.WIDTH(4), .DC_POLICY(1'b0), .MAX_RETRY(MAXR)) u0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy0),
        .q_fb(b0), .j(j0), .k(k0), .busy(busy0), .done(done0), .err(err0), .err_clr(err_clr));

    jk_exciter #(.WIDTH(4), .DC_POLICY(1'b1), .MAX_RETRY(MAXR)) u1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy1),
        .q_fb(b1), .j(j1), .k(k1), .busy(busy1), .done(done1), .err(err1), .err_clr(err_clr));

    always #5 clk = ~clk;

    // external JK banks; stuck bits read back as 0 regardless of excitation
    always @(posedge clk) begin
        b0 <= ((j0 & ~b0) | (~k0 & b0)) & ~stuck;
        b1 <= ((j1 & ~b1) | (~k1 & b1)) & ~stuck;
    end

    function automatic void excite(input logic [3:0] c, input logic [3:0] t, input logic dc,
                                   output logic [3:0] ej, output logic [3:0] ek);
        for (int i = 0; i < 4; i++) begin
            case ({c[i], t[i]})
                2'b00:   begin ej[i] = 1'b0; ek[i] = dc;   end
                2'b01:   begin ej[i] = 1'b1; ek[i] = dc;   end
                2'b10:   begin ej[i] = dc;   ek[i] = 1'b1; end
                default: begin ej[i] = dc;   ek[i] = 1'b0; end
            endcase
        end
    endfunction

    task automatic run_xfer(input logic [3:0] t, input logic [3:0] s, input bit hold, input bit clr);
        logic [3:0] cur, after, ej0, ek0, ej1, ek1;
        bit ok;
        stuck = s;
        @(negedge clk);
        mq = mq & ~s;
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            $display("FAIL ready_idle: got %b want 11", {rdy0, rdy1}); fails++;
        end
        tgt_valid = 1'b1;
        tgt_data  = t;
        cur   = mq;
        after = t & ~s;
        ok    = after == t;
        @(negedge clk);
        tgt_valid = hold;
        for (int a = 0; a <= MAXR; a++) begin
            excite(cur, t, 1'b0, ej0, ek0);
            excite(cur, t, 1'b1, ej1, ek1);
            checks++;
            if ({j0, k0, j1, k1} !== {ej0, ek0, ej1, ek1}) begin
                $display("FAIL drive_jk: t=%b try=%0d got j0=%b k0=%b j1=%b k1=%b want %b %b %b %b",
                         t, a, j0, k0, j1, k1, ej0, ek0, ej1, ek1); fails++;
            end
            checks++;
            if ({busy0, busy1, rdy0, rdy1, done0, done1, err0, err1} !== {6'b110000, exp_err, exp_err}) begin
                $display("FAIL drive_status: got %b want %b", {busy0, busy1, rdy0, rdy1, done0, done1, err0, err1},
                         {6'b110000, exp_err, exp_err}); fails++;
            end
            if (hold) tgt_data = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({j0, k0, j1, k1} !== 16'h0) begin
                $display("FAIL check_jk: got %h want 0000", {j0, k0, j1, k1}); fails++;
            end
            checks++;
            if ({busy0, busy1, rdy0, rdy1, done0, done1, err0, err1} !== {6'b110000, exp_err, exp_err}) begin
                $display("FAIL check_status: got %b want %b", {busy0, busy1, rdy0, rdy1, done0, done1, err0, err1},
                         {6'b110000, exp_err, exp_err}); fails++;
            end
            if (hold) tgt_data = 4'($urandom);
            if (clr && (ok || a == MAXR)) err_clr = 1'b1;
            @(negedge clk);
            if (ok) break;
            cur = after;
        end
        if (!ok) exp_err = 1'b1;
        tgt_valid = 1'b0;
        err_clr   = 1'b0;
        mq        = after;
        checks++;
        if ({done0, done1, err0, err1, busy0, busy1, rdy0, rdy1} !== {ok, ok, exp_err, exp_err, 4'b0011}) begin
            $display("FAIL end_status: t=%b got %b want %b", t, {done0, done1, err0, err1, busy0, busy1, rdy0, rdy1},
                     {ok, ok, exp_err, exp_err, 4'b0011}); fails++;
        end
        checks++;
        if ({b0, b1} !== {after, after}) begin
            $display("FAIL bank_value: got %b %b want %b", b0, b1, after); fails++;
        end
        @(negedge clk);
        checks++;
        if ({done0, done1} !== 2'b00) begin
            $display("FAIL done_pulse: got %b want 00", {done0, done1}); fails++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({j0, k0, j1, k1, busy0, busy1, done0, done1, err0, err1, rdy0, rdy1} !== 26'h0) begin
            $display("FAIL reset_outputs: got %h want 0", {j0, k0, j1, k1, busy0, busy1, done0, done1, err0, err1, rdy0, rdy1});
            fails++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b00) begin
            $display("FAIL ready_before_edge: got %b want 00", {rdy0, rdy1}); fails++;
        end
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            $display("FAIL ready_after_release: got %b want 11", {rdy0, rdy1}); fails++;
        end
    endtask

    task automatic test_basic();
        run_xfer(4'b1010, 4'h0, 1'b0, 1'b0);
        run_xfer(4'b1010, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_dont_care();
        run_xfer(4'b1100, 4'h0, 1'b0, 1'b0);
        run_xfer(4'b1010, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_retry_err();
        run_xfer(4'b0000, 4'h0, 1'b0, 1'b0);
        run_xfer(4'b0001, 4'b0001, 1'b0, 1'b0);
        run_xfer(4'b0110, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_err_clr();
        run_xfer(4'b0000, 4'h0, 1'b0, 1'b0);
        run_xfer(4'b0001, 4'b0001, 1'b0, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        checks++;
        if ({err0, err1} !== 2'b00) begin
            $display("FAIL err_clr_alone: got %b want 00", {err0, err1}); fails++;
        end
    endtask

    task automatic test_busy_ignore();
        run_xfer(4'($urandom), 4'h0, 1'b1, 1'b0);
        run_xfer(4'($urandom), 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++)
            run_xfer(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'($urandom), 1'b0);
    endtask

    task automatic test_reset_mid_drive();
        logic [3:0] ej0, ek0, ej1, ek1;
        run_xfer(4'b0000, 4'h0, 1'b0, 1'b0);
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        @(negedge clk);
        tgt_valid = 1'b0;
        excite(mq, 4'b0110, 1'b0, ej0, ek0);
        excite(mq, 4'b0110, 1'b1, ej1, ek1);
        checks++;
        if ({j0, k0, j1, k1} !== {ej0, ek0, ej1, ek1}) begin
            $display("FAIL abort_drive_jk: got %h want %h", {j0, k0, j1, k1}, {ej0, ek0, ej1, ek1}); fails++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({j0, k0, j1, k1, busy0, busy1, done0, done1, err0, err1, rdy0, rdy1} !== 26'h0) begin
            $display("FAIL abort_outputs: got %h want 0", {j0, k0, j1, k1, busy0, busy1, done0, done1, err0, err1, rdy0, rdy1});
            fails++;
        end
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if ({done0, done1, err0, err1, busy0, busy1, rdy0, rdy1} !== 8'b00000011) begin
                $display("FAIL abort_after: cyc=%0d got %b want 00000011", n,
                         {done0, done1, err0, err1, busy0, busy1, rdy0, rdy1}); fails++;
            end
        end
        checks++;
        if ({b0, b1} !== {mq, mq}) begin
            $display("FAIL abort_bank: got %b %b want %b", b0, b1, mq); fails++;
        end
        run_xfer(4'b1001, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dont_care();
        test_retry_err();
        test_err_clr();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
